// File: rtl/regfile_sequencer_pkg.sv
// Shared definitions for the 4-bit processor: opcodes, ALU encodings,
// control FSM states and instruction field positions.
package regfile_sequencer_pkg;

  localparam int OPC_HI = 7;
  localparam int OPC_LO = 4;
  localparam int RD_HI  = 3;
  localparam int RD_LO  = 2;
  localparam int RS_HI  = 1;
  localparam int RS_LO  = 0;
  localparam int IMM_HI = 3;
  localparam int IMM_LO = 0;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_MOV = 4'h2;
  localparam logic [3:0] OP_LDA = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_JMP = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;

  // Source of the result register latched in EXECUTE.
  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_IMM = 2'd1;
  localparam logic [1:0] SRC_REG = 2'd2;
  localparam logic [1:0] SRC_ACC = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } state_t;

endpackage

// File: rtl/regfile_seq_decode.sv
// Combinational opcode decoder: turns a 4-bit opcode into the control
// flags the sequencer needs for EXECUTE and WRITEBACK.
module regfile_seq_decode
  import regfile_sequencer_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       acc_we,
  output logic       reg_we,
  output logic       is_jump,
  output logic       is_cond,
  output logic       is_halt,
  output logic [1:0] src_sel,
  output logic [2:0] alu_op
);

  always_comb begin
    acc_we  = 1'b0;
    reg_we  = 1'b0;
    is_jump = 1'b0;
    is_cond = 1'b0;
    is_halt = 1'b0;
    src_sel = SRC_ALU;
    alu_op  = ALU_ADD;
    case (opcode)
      OP_NOP: ;
      OP_LDI: begin acc_we = 1'b1; src_sel = SRC_IMM; end
      OP_MOV: begin reg_we = 1'b1; src_sel = SRC_ACC; end
      OP_LDA: begin acc_we = 1'b1; src_sel = SRC_REG; end
      OP_ADD: begin acc_we = 1'b1; alu_op = ALU_ADD; end
      OP_SUB: begin acc_we = 1'b1; alu_op = ALU_SUB; end
      OP_AND: begin acc_we = 1'b1; alu_op = ALU_AND; end
      OP_OR:  begin acc_we = 1'b1; alu_op = ALU_OR;  end
      OP_XOR: begin acc_we = 1'b1; alu_op = ALU_XOR; end
      OP_JZ:  begin is_jump = 1'b1; is_cond = 1'b1; end
      OP_JMP: is_jump = 1'b1;
      OP_HLT: is_halt = 1'b1;
      // Opcodes B-E fall through with every flag low: they behave as NOP.
      default: ;
    endcase
  end

endmodule

// File: rtl/regfile_sequencer.sv
// Four-state-per-instruction control unit: fetches from ROM, decodes, and is
// the sole driver of the register file and accumulator write ports.
module regfile_sequencer
  import regfile_sequencer_pkg::*;
#(
  parameter int                  PC_WIDTH = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic [PC_WIDTH-1:0] pc,
  input  logic [7:0]          instr_data,
  output logic [1:0]          read_addr1,
  input  logic [3:0]          read_data1,
  input  logic [3:0]          acc_out,
  output logic [2:0]          alu_op,
  input  logic [3:0]          alu_result,
  output logic                write_enable,
  output logic [1:0]          write_addr,
  output logic [3:0]          write_data,
  output logic                acc_write_enable,
  output logic [3:0]          acc_in,
  output logic                busy,
  output logic                halted,
  output logic [2:0]          fsm_state
);

  state_t     state, state_next;
  logic [7:0] ir;
  logic [3:0] res, res_next;
  logic       z;

  logic       dec_acc_we, dec_reg_we, dec_is_jump, dec_is_cond, dec_is_halt;
  logic [1:0] dec_src_sel;
  logic [2:0] dec_alu_op;
  logic       jump_taken;
  logic [PC_WIDTH-1:0] jump_target;

  regfile_seq_decode u_decode (
    .opcode  (ir[OPC_HI:OPC_LO]),
    .acc_we  (dec_acc_we),
    .reg_we  (dec_reg_we),
    .is_jump (dec_is_jump),
    .is_cond (dec_is_cond),
    .is_halt (dec_is_halt),
    .src_sel (dec_src_sel),
    .alu_op  (dec_alu_op)
  );

  assign jump_taken  = dec_is_jump & (~dec_is_cond | z);
  assign jump_target = PC_WIDTH'(ir[IMM_HI:IMM_LO]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (start) state_next = ST_FETCH;
      ST_FETCH:     state_next = ST_DECODE;
      ST_DECODE:    state_next = dec_is_halt ? ST_HALT : ST_EXECUTE;
      ST_EXECUTE:   state_next = ST_WRITEBACK;
      ST_WRITEBACK: state_next = ST_FETCH;
      ST_HALT:      state_next = ST_HALT;
      default:      state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    res_next = alu_result;
    case (dec_src_sel)
      SRC_IMM: res_next = ir[IMM_HI:IMM_LO];
      SRC_REG: res_next = read_data1;
      SRC_ACC: res_next = acc_out;
      default: res_next = alu_result;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc  <= RESET_PC;
      ir  <= '0;
      res <= '0;
      z   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE:    if (start) pc <= RESET_PC;
        ST_FETCH:   ir <= instr_data;
        ST_EXECUTE: res <= res_next;
        ST_WRITEBACK: begin
          pc <= jump_taken ? jump_target : pc + PC_WIDTH'(1);
          if (dec_acc_we) z <= (res == 4'd0);
        end
        default: ;
      endcase
    end
  end

  // Strobes are decoded straight from state, so an asynchronous reset
  // removes them in the same instant and a cut-short instruction writes nothing.
  always_comb begin
    read_addr1       = 2'd0;
    alu_op           = 3'd0;
    write_enable     = 1'b0;
    write_addr       = 2'd0;
    write_data       = 4'd0;
    acc_write_enable = 1'b0;
    acc_in           = 4'd0;
    if (state == ST_DECODE || state == ST_EXECUTE || state == ST_WRITEBACK)
      read_addr1 = ir[RS_HI:RS_LO];
    if (state == ST_EXECUTE)
      alu_op = dec_alu_op;
    if (state == ST_WRITEBACK) begin
      if (dec_reg_we) begin
        write_enable = 1'b1;
        write_addr   = ir[RD_HI:RD_LO];
        write_data   = res;
      end else if (dec_acc_we) begin
        acc_write_enable = 1'b1;
        acc_in           = res;
      end
    end
  end

  assign busy      = (state != ST_IDLE) && (state != ST_HALT);
  assign halted    = (state == ST_HALT);
  assign fsm_state = state;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: ROM, register file, accumulator and ALU are
// modelled around the DUT; an instruction-level interpreter predicts writes.
module tb_regfile_sequencer;
  import regfile_sequencer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] pc;
  logic [7:0] instr_data;
  logic [1:0] read_addr1;
  logic [3:0] read_data1, acc_out, alu_result;
  logic [2:0] alu_op;
  logic       write_enable, acc_write_enable, busy, halted;
  logic [1:0] write_addr;
  logic [3:0] write_data, acc_in;
  logic [2:0] fsm_state;

  regfile_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .pc(pc), .instr_data(instr_data),
    .read_addr1(read_addr1), .read_data1(read_data1), .acc_out(acc_out),
    .alu_op(alu_op), .alu_result(alu_result), .write_enable(write_enable),
    .write_addr(write_addr), .write_data(write_data),
    .acc_write_enable(acc_write_enable), .acc_in(acc_in), .busy(busy),
    .halted(halted), .fsm_state(fsm_state)
  );

  // ---------------- environment: ROM, regfile, accumulator, ALU ----------------
  logic [7:0] rom [16];
  logic [3:0] regs [4];
  logic [3:0] acc;
  logic       pre_go = 1'b0;
  logic [3:0] pre_acc;
  logic [3:0] pre_regs [4];

  function automatic logic [3:0] alu4(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      default: return 4'd0;
    endcase
  endfunction

  assign instr_data = rom[pc];
  assign read_data1 = regs[read_addr1];
  assign acc_out    = acc;
  assign alu_result = alu4(alu_op, acc, read_data1);

  always @(posedge clk) begin
    if (pre_go) begin
      acc <= pre_acc;
      for (int i = 0; i < 4; i++) regs[i] <= pre_regs[i];
    end else begin
      if (acc_write_enable) acc <= acc_in;
      if (write_enable) regs[write_addr] <= write_data;
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [11:0] exp_q[$];   // {pc, kind(0 none/1 acc/2 reg), addr, data}
  bit exp_halt;
  int n_exp;
  int halt_edge;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Instruction-level interpreter of the ISA, starting from the current
  // environment contents with Z cleared and PC at 0.
  task automatic model_run(input int cap);
    logic [3:0] m_acc, m_pc, nxt, op, imm, data;
    logic [3:0] m_regs [4];
    logic [1:0] rd, rs, kind, addr;
    logic [7:0] ins;
    bit m_z;
    m_acc = acc; m_regs = regs; m_pc = 4'd0; m_z = 1'b0;
    n_exp = 0; exp_halt = 1'b0;
    exp_q.delete();
    while (n_exp < cap) begin
      ins = rom[m_pc];
      op = ins[7:4]; rd = ins[3:2]; rs = ins[1:0]; imm = ins[3:0];
      if (op == 4'hF) begin exp_halt = 1'b1; break; end
      kind = 2'd0; addr = 2'd0; data = 4'd0; nxt = m_pc + 4'd1;
      case (op)
        4'h1: begin m_acc = imm; kind = 2'd1; end
        4'h2: begin m_regs[rd] = m_acc; kind = 2'd2; addr = rd; data = m_acc; end
        4'h3: begin m_acc = m_regs[rs]; kind = 2'd1; end
        4'h4: begin m_acc = m_acc + m_regs[rs]; kind = 2'd1; end
        4'h5: begin m_acc = m_acc - m_regs[rs]; kind = 2'd1; end
        4'h6: begin m_acc = m_acc & m_regs[rs]; kind = 2'd1; end
        4'h7: begin m_acc = m_acc | m_regs[rs]; kind = 2'd1; end
        4'h8: begin m_acc = m_acc ^ m_regs[rs]; kind = 2'd1; end
        4'h9: if (m_z) nxt = imm;
        4'hA: nxt = imm;
        default: ;
      endcase
      if (kind == 2'd1) begin data = m_acc; m_z = (m_acc == 4'd0); end
      exp_q.push_back({m_pc, kind, addr, data});
      m_pc = nxt;
      n_exp++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_outputs", {pc, read_addr1, alu_op, write_enable, write_addr, write_data,
                          acc_write_enable, acc_in, busy, halted}, 23'd0);
    check("rst_state", fsm_state, ST_IDLE);
    reset = 1'b1;
  endtask

  task automatic preload(input logic [3:0] a, input logic [3:0] r0, input logic [3:0] r1,
                         input logic [3:0] r2, input logic [3:0] r3);
    pre_acc = a;
    pre_regs[0] = r0; pre_regs[1] = r1; pre_regs[2] = r2; pre_regs[3] = r3;
    pre_go = 1'b1;
    @(negedge clk);
    pre_go = 1'b0;
  endtask

  task automatic fill_rom(input logic [7:0] v);
    for (int i = 0; i < 16; i++) rom[i] = v;
  endtask

  task automatic run_program(input string tag, input int cap);
    int edge_cnt, budget;
    logic [3:0] cur_pc;
    logic [7:0] ins;
    logic [1:0] kind, addr;
    logic [3:0] data;
    logic [2:0] exp_alu;
    model_run(cap);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    edge_cnt = 1; halt_edge = 0; cur_pc = 4'd0; budget = 4 * cap + 24;
    while (budget > 0) begin
      if (fsm_state == ST_FETCH) cur_pc = pc;
      if (fsm_state == ST_EXECUTE) begin
        ins = rom[cur_pc];
        exp_alu = (ins[7:4] >= 4'h4 && ins[7:4] <= 4'h8) ? 3'(ins[7:4] - 4'h4) : 3'd0;
        check({tag, "_alu_op"}, alu_op, exp_alu);
        check({tag, "_read_addr1"}, read_addr1, ins[1:0]);
      end
      if (fsm_state == ST_WRITEBACK) begin
        check({tag, "_dual_strobe"}, write_enable & acc_write_enable, 1'b0);
        kind = acc_write_enable ? 2'd1 : (write_enable ? 2'd2 : 2'd0);
        addr = write_enable ? write_addr : 2'd0;
        data = acc_write_enable ? acc_in : (write_enable ? write_data : 4'd0);
        if (exp_q.size() > 0) check({tag, "_wb"}, {cur_pc, kind, addr, data}, exp_q.pop_front());
        else check({tag, "_extra_wb"}, 1'b1, 1'b0);
      end else begin
        check({tag, "_stray_strobe"}, {write_enable, acc_write_enable}, 2'd0);
      end
      if (halted && halt_edge == 0) halt_edge = edge_cnt;
      if (exp_q.size() == 0 && (!exp_halt || halt_edge != 0)) break;
      @(negedge clk);
      edge_cnt++; budget--;
    end
    if (budget == 0) check({tag, "_timeout"}, 1'b1, 1'b0);
    if (exp_halt) check({tag, "_halt_edge"}, halt_edge, 4 * n_exp + 3);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [3:0] frozen_pc;
    int b;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    preload(4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    do_reset();

    // Basic program: LDI 5, MOV R1, ADD R1, HLT
    fill_rom(8'hF0);
    rom[0] = 8'h15; rom[1] = 8'h24; rom[2] = 8'h41; rom[3] = 8'hF0;
    run_program("p1", 16);
    check("p1_halt_at_15", halt_edge, 15);
    check("p1_acc", acc, 4'hA);
    check("p1_r1", regs[1], 4'h5);
    check("p1_busy", busy, 1'b0);

    // Start is ignored in HALT
    frozen_pc = pc;
    @(negedge clk); start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("halt_stays", halted, 1'b1);
    check("halt_pc_frozen", pc, frozen_pc);
    check("halt_state", fsm_state, ST_HALT);

    // Wrap to zero sets Z; JZ taken, later JZ not taken
    do_reset();
    preload(4'd0, 4'd0, 4'd1, 4'd0, 4'd0);
    fill_rom(8'hF0);
    rom[0] = 8'h1F; rom[1] = 8'h41; rom[2] = 8'h97;
    rom[7] = 8'h11; rom[8] = 8'h90; rom[9] = 8'hF0;
    run_program("zflag", 16);
    check("zflag_acc", acc, 4'h1);

    // JMP from pc 15 to 3
    do_reset();
    fill_rom(8'hF0);
    rom[0] = 8'hAF; rom[15] = 8'hA3; rom[3] = 8'hF0;
    run_program("jmp15", 16);

    // NOP at pc 15 wraps to 0 (program loops; bounded by cap)
    do_reset();
    fill_rom(8'h00);
    rom[0] = 8'hAE;
    run_program("wrap", 7);

    // Illegal opcodes behave as NOP
    do_reset();
    fill_rom(8'hF0);
    rom[0] = 8'h11; rom[1] = 8'hC5; rom[2] = 8'hD0; rom[3] = 8'hF0;
    run_program("illegal", 16);

    // Reset during EXECUTE of LDI 9
    do_reset();
    preload(4'd3, 4'd0, 4'd0, 4'd0, 4'd0);
    fill_rom(8'hF0);
    rom[0] = 8'h19;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    b = 0;
    while (fsm_state != ST_EXECUTE && b < 12) begin @(negedge clk); b++; end
    check("exec_reached", b < 12, 1'b1);
    reset = 1'b0;
    #1;
    check("midrst_outputs", {pc, read_addr1, alu_op, write_enable, write_addr, write_data,
                             acc_write_enable, acc_in, busy, halted}, 23'd0);
    check("midrst_state", fsm_state, ST_IDLE);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("midrst_no_acc_we", acc_write_enable, 1'b0);
    end
    check("midrst_acc_kept", acc, 4'd3);
    run_program("restart", 16);
    check("restart_acc", acc, 4'd9);

    // Randomized programs
    for (int t = 0; t < 8; t++) begin
      do_reset();
      preload(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      for (int i = 0; i < 16; i++) rom[i] = 8'($urandom_range(0, 255));
      run_program($sformatf("rand%0d", t), 24);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "global timeout");
  end

endmodule
